// File: rtl/vga_timing_monitor_if.sv
// ============================================================================
// vga_timing_monitor_if
// ----------------------------------------------------------------------------
// Groups the raw VGA signals that travel from the timing driver into the
// loopback monitor.
//
// Signals:
//   vga_hs   horizontal sync, polarity set by the monitor's SYNC_POL
//   vga_vs   vertical sync, same polarity as vga_hs
//   vga_rgb  12-bit 4:4:4 pixel data
//
// Modports:
//   master   the side that drives the video (driver or testbench)
//   slave    the side that consumes it (vga_timing_monitor)
// ============================================================================
interface vga_timing_monitor_if;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] vga_rgb;

    modport master (output vga_hs, output vga_vs, output vga_rgb);
    modport slave  (input  vga_hs, input  vga_vs, input  vga_rgb);
endinterface

// File: rtl/vga_timing_monitor.sv
// ============================================================================
// vga_timing_monitor
// ----------------------------------------------------------------------------
// Receive-side loopback checker for the VGA timing driver. Rebuilds pixel
// coordinates from the sync edges, measures line and frame lengths, locks
// once the programmed timing is seen for LOCK_FRAMES consecutive frames,
// counts timing errors and captures the colour of one probe pixel.
//
// Ports:
//   vga_clk      pixel clock, all logic runs on it
//   vga_rst      synchronous reset, active-high
//   vga          video input bundle (vga_hs, vga_vs, vga_rgb), slave modport
//   probe_x/y    probe coordinate, sampled at every frame start
//   pixel_xpos   reconstructed active column (0 outside the active area)
//   pixel_ypos   reconstructed active row    (0 outside the active area)
//   pixel_de     high while the reconstructed position is active
//   h_period     last measured line length in clocks
//   v_lines      last measured frame length in lines
//   locked       timing lock status
//   err_cnt      saturating timing error count
//   probe_rgb    colour captured at the probe pixel
//   probe_valid  one-clock pulse when probe_rgb updates
//   frame_sum    per-frame checksum of active pixels
//
// Build option:
//   VGA_MON_CHECKSUM_EN  when defined, frame_sum carries the modulo-2^16 sum
//                        of the active pixels of the previous frame; when
//                        undefined, frame_sum is tied to zero.
// ============================================================================
module vga_timing_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_DISP      = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_DISP      = 480,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                 vga_clk,
    input  logic                 vga_rst,
    vga_timing_monitor_if.slave  vga,
    input  logic [10:0]          probe_x,
    input  logic [10:0]          probe_y,
    output logic [10:0]          pixel_xpos,
    output logic [10:0]          pixel_ypos,
    output logic                 pixel_de,
    output logic [10:0]          h_period,
    output logic [10:0]          v_lines,
    output logic                 locked,
    output logic [15:0]          err_cnt,
    output logic [11:0]          probe_rgb,
    output logic                 probe_valid,
    output logic [15:0]          frame_sum
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] V_ACT_BEG = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] H_DISP_W  = 11'(H_DISP);
    localparam logic [10:0] V_DISP_W  = 11'(V_DISP);
    localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);

    localparam int              GOOD_W      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    // ------------------------------------------------------------------------
    // Input sampling and sync edge detection
    // ------------------------------------------------------------------------
    logic        s_hs, s_vs, d_hs, d_vs;
    logic [11:0] s_rgb, rgb_d1, rgb_d2;
    logic        hs_start, vs_start;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours regardless of
    // statement order.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            // Sync registers reset to the inactive level so release of reset
            // cannot fake a sync edge.
            s_hs   <= ~SYNC_POL;
            s_vs   <= ~SYNC_POL;
            d_hs   <= ~SYNC_POL;
            d_vs   <= ~SYNC_POL;
            s_rgb  <= '0;
            rgb_d1 <= '0;
            rgb_d2 <= '0;
        end else begin
            s_hs   <= vga.vga_hs;
            s_vs   <= vga.vga_vs;
            d_hs   <= s_hs;
            d_vs   <= s_vs;
            s_rgb  <= vga.vga_rgb;
            rgb_d1 <= s_rgb;
            rgb_d2 <= rgb_d1;
        end
    end

    assign hs_start = (s_hs == SYNC_POL) && (d_hs != SYNC_POL);
    assign vs_start = (s_vs == SYNC_POL) && (d_vs != SYNC_POL);

    // ------------------------------------------------------------------------
    // Line / frame counters and period measurement
    // ------------------------------------------------------------------------
    logic [10:0] h_cnt, v_cnt;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            h_cnt    <= '0;
            h_period <= '0;
        end else if (hs_start) begin
            h_period <= h_cnt + 11'd1;
            h_cnt    <= '0;
        end else if (h_cnt != CNT_MAX) begin
            h_cnt    <= h_cnt + 11'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            v_cnt   <= '0;
            v_lines <= '0;
        end else if (vs_start) begin
            v_lines <= v_cnt + 11'd1;
            v_cnt   <= '0;
        end else if (hs_start && (v_cnt != CNT_MAX)) begin
            v_cnt   <= v_cnt + 11'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Active-area decode
    // ------------------------------------------------------------------------
    logic de_next;

    assign de_next = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END) &&
                     (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            pixel_de   <= 1'b0;
            pixel_xpos <= '0;
            pixel_ypos <= '0;
        end else begin
            pixel_de   <= de_next;
            pixel_xpos <= de_next ? (h_cnt - H_ACT_BEG) : 11'd0;
            pixel_ypos <= de_next ? (v_cnt - V_ACT_BEG) : 11'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Frame judgement
    // ------------------------------------------------------------------------
    logic h_line_bad, frame_bad, frame_good;
    logic h_stalled, h_timeout;

    // The line closed by an hs_start that coincides with vs_start still
    // belongs to the frame being judged, so it is folded in directly.
    assign h_line_bad = hs_start && ((h_cnt + 11'd1) != H_TOTAL_W);
    assign frame_good = ((v_cnt + 11'd1) == V_TOTAL_W) && !frame_bad && !h_line_bad;

    // h_stalled makes a saturated line counter count as one error only.
    assign h_timeout  = (h_cnt == CNT_MAX) && !hs_start && !h_stalled;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            frame_bad <= 1'b0;
            h_stalled <= 1'b0;
        end else begin
            if (vs_start)        frame_bad <= 1'b0;
            else if (h_line_bad) frame_bad <= 1'b1;

            if (hs_start)        h_stalled <= 1'b0;
            else if (h_timeout)  h_stalled <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------------
    lock_state_t       state, state_next;
    logic [GOOD_W-1:0] good_cnt, good_next;
    logic              err_inc;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves one unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_inc    = 1'b0;
        if (h_timeout) begin
            state_next = SEARCH;
            good_next  = '0;
            err_inc    = 1'b1;
        end else if (vs_start) begin
            unique case (state)
                SEARCH: begin
                    // The partial frame before the first edge is not judged.
                    state_next = TRACK;
                    good_next  = '0;
                end
                TRACK: begin
                    if (!frame_good) begin
                        good_next = '0;
                    end else if ((good_cnt + GOOD_W'(1)) == LOCK_TARGET) begin
                        state_next = LOCKED;
                        good_next  = good_cnt + GOOD_W'(1);
                    end else begin
                        good_next  = good_cnt + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    if (!frame_good) begin
                        state_next = TRACK;
                        good_next  = '0;
                        err_inc    = 1'b1;
                    end
                end
                default: begin
                    state_next = SEARCH;
                    good_next  = '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge vga_clk) begin
        if (vga_rst)                           err_cnt <= '0;
        else if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end

    // ------------------------------------------------------------------------
    // Probe capture
    // ------------------------------------------------------------------------
    // rgb_d2 is the colour that entered on the same clock as the sync sample
    // behind the current pixel_de/xpos/ypos, so the captured colour belongs
    // to exactly the reported pixel.
    logic [10:0] probe_x_q, probe_y_q;
    logic        probe_armed;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            probe_x_q   <= '0;
            probe_y_q   <= '0;
            probe_armed <= 1'b0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
        end else begin
            probe_valid <= 1'b0;
            if (vs_start) begin
                probe_x_q   <= probe_x;
                probe_y_q   <= probe_y;
                probe_armed <= (probe_x < H_DISP_W) && (probe_y < V_DISP_W);
            end else if (probe_armed && pixel_de &&
                         (pixel_xpos == probe_x_q) && (pixel_ypos == probe_y_q)) begin
                probe_rgb   <= rgb_d2;
                probe_valid <= 1'b1;
                probe_armed <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional per-frame checksum
    // ------------------------------------------------------------------------
`ifdef VGA_MON_CHECKSUM_EN
    logic [15:0] sum_acc;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (vs_start) begin
            frame_sum <= sum_acc;
            sum_acc   <= pixel_de ? {4'b0, rgb_d2} : 16'd0;
        end else if (pixel_de) begin
            sum_acc   <= sum_acc + {4'b0, rgb_d2};
        end
    end
`else
    assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// ============================================================================
// tb_vga_timing_monitor
// ----------------------------------------------------------------------------
// Drives scaled-down VGA frames (32 x 16 clocks, 16 x 8 active) into the
// monitor. Every active pixel and every probe hit is pushed to a scoreboard
// as it is driven and popped when the monitor reports it; lock state, error
// count and measurements are compared at each frame start.
// ============================================================================
module tb_vga_timing_monitor;

    localparam int H_SYNC      = 8;
    localparam int H_BACK      = 4;
    localparam int H_DISP      = 16;
    localparam int H_TOTAL     = 32;
    localparam int V_SYNC      = 2;
    localparam int V_BACK      = 3;
    localparam int V_DISP      = 8;
    localparam int V_TOTAL     = 16;
    localparam int LOCK_FRAMES = 2;
    localparam int H_BEG       = H_SYNC + H_BACK;
    localparam int V_BEG       = V_SYNC + V_BACK;
    // Clocks from driving a pixel to seeing it on pixel_de.
    localparam int DE_LAT      = 3;

    logic        vga_clk = 1'b0;
    logic        vga_rst;
    logic [10:0] probe_x, probe_y;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic        pixel_de;
    logic [10:0] h_period, v_lines;
    logic        locked;
    logic [15:0] err_cnt;
    logic [11:0] probe_rgb;
    logic        probe_valid;
    logic [15:0] frame_sum;

    vga_timing_monitor_if vga_bus ();

    vga_timing_monitor #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_TOTAL(V_TOTAL),
        .SYNC_POL(1'b0), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .vga_clk     (vga_clk),
        .vga_rst     (vga_rst),
        .vga         (vga_bus),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .pixel_de    (pixel_de),
        .h_period    (h_period),
        .v_lines     (v_lines),
        .locked      (locked),
        .err_cnt     (err_cnt),
        .probe_rgb   (probe_rgb),
        .probe_valid (probe_valid),
        .frame_sum   (frame_sum)
    );

    always #5 vga_clk = ~vga_clk;

    int unsigned cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboards
    // ------------------------------------------------------------------------
    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        int unsigned cyc;
    } pix_t;

    pix_t        de_q[$];
    logic [11:0] probe_q[$];
    logic [15:0] prev_sum = '0;
    pix_t        mon_pix;

    always @(negedge vga_clk) begin
        if (!vga_rst) begin
            if (pixel_de) begin
                if (de_q.size() == 0) begin
                    check("de_spurious", 32'd1, 32'd0);
                end else begin
                    mon_pix = de_q.pop_front();
                    check("de_pos", {10'd0, pixel_xpos, pixel_ypos}, {10'd0, mon_pix.x, mon_pix.y});
                    check("de_lat", cyc - mon_pix.cyc, DE_LAT);
                end
            end else begin
                check("idle_pos", {10'd0, pixel_xpos, pixel_ypos}, 32'd0);
            end
            if (probe_valid) begin
                if (probe_q.size() == 0) check("probe_spurious", 32'd1, 32'd0);
                else                     check("probe_rgb", probe_rgb, probe_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    function automatic logic [11:0] pix_colour(input int x, input int y, input bit solid);
        logic [3:0] xn, yn;
        if (solid) return 12'h001;
        if (x == 5 && y == 3) return 12'hF00;
        xn = 4'(x);
        yn = 4'(y);
        return {xn, yn, 4'hA};
    endfunction

    task automatic drive_clk(input logic hs, input logic vs, input logic [11:0] rgb);
        @(posedge vga_clk);
        #1;
        vga_bus.vga_hs  = hs;
        vga_bus.vga_vs  = vs;
        vga_bus.vga_rgb = rgb;
    endtask

    // One frame; the frame-start checks run after the monitor has processed
    // this frame's vs edge. short_line < 0 means all lines are nominal.
    task automatic drive_frame(input int short_line, input bit solid,
                               input bit exp_locked, input int exp_err, input bit chk_meas);
        logic [15:0] sum;
        logic [11:0] c;
        bit          act;
        int          len;
        pix_t        p;
        sum = '0;
        for (int ly = 0; ly < V_TOTAL; ly++) begin
            len = (ly == short_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int px = 0; px < len; px++) begin
                if (ly == 0 && px == 4) begin
                    check("locked", locked, exp_locked);
                    check("err_cnt", err_cnt, exp_err);
                    if (chk_meas) begin
                        check("h_period", h_period, H_TOTAL);
                        check("v_lines", v_lines, V_TOTAL);
                    end
`ifdef VGA_MON_CHECKSUM_EN
                    check("frame_sum", frame_sum, prev_sum);
`else
                    check("frame_sum", frame_sum, 32'd0);
`endif
                end
                act = (px >= H_BEG) && (px < H_BEG + H_DISP) &&
                      (ly >= V_BEG) && (ly < V_BEG + V_DISP);
                c = act ? pix_colour(px - H_BEG, ly - V_BEG, solid) : 12'h000;
                drive_clk(px >= H_SYNC, ly >= V_SYNC, c);
                if (act) begin
                    p.x   = 11'(px - H_BEG);
                    p.y   = 11'(ly - V_BEG);
                    p.cyc = cyc;
                    de_q.push_back(p);
                    if (p.x == probe_x && p.y == probe_y) probe_q.push_back(c);
                    sum = sum + {4'b0, c};
                end
            end
        end
        prev_sum = sum;
    endtask

    initial begin
        vga_bus.vga_hs  = 1'b1;
        vga_bus.vga_vs  = 1'b1;
        vga_bus.vga_rgb = '0;
        probe_x = 11'd5;
        probe_y = 11'd3;
        vga_rst = 1'b1;
        repeat (4) @(posedge vga_clk);
        #1;
        check("rst_locked", locked, 32'd0);
        check("rst_err", err_cnt, 32'd0);
        check("rst_h_period", h_period, 32'd0);
        check("rst_v_lines", v_lines, 32'd0);
        check("rst_de", pixel_de, 32'd0);
        check("rst_pos", {10'd0, pixel_xpos, pixel_ypos}, 32'd0);
        check("rst_probe", {probe_valid, probe_rgb}, 32'd0);
        check("rst_sum", frame_sum, 32'd0);
        vga_rst = 1'b0;
        repeat (3) drive_clk(1'b1, 1'b1, 12'h000);

        // Acquisition: lock at the third frame start.
        drive_frame(-1, 1'b0, 1'b0, 0, 1'b0);
        drive_frame(-1, 1'b0, 1'b0, 0, 1'b1);
        drive_frame(-1, 1'b0, 1'b1, 0, 1'b1);
        // One short line while locked, then recovery over two clean frames.
        drive_frame(7,  1'b0, 1'b1, 0, 1'b1);
        drive_frame(-1, 1'b0, 1'b0, 1, 1'b1);
        drive_frame(-1, 1'b0, 1'b0, 1, 1'b1);
        drive_frame(-1, 1'b0, 1'b1, 1, 1'b1);

        // Sync loss: hs held inactive long enough to saturate the line counter.
        repeat (2100) drive_clk(1'b1, 1'b1, 12'h000);
        check("stall_locked", locked, 32'd0);
        check("stall_err", err_cnt, 32'd2);

        drive_frame(-1, 1'b0, 1'b0, 2, 1'b0);
        drive_frame(-1, 1'b0, 1'b0, 2, 1'b1);
        drive_frame(-1, 1'b0, 1'b1, 2, 1'b1);

        // Out-of-range probe column: no capture expected.
        probe_x = 11'd20;
        drive_frame(-1, 1'b0, 1'b1, 2, 1'b1);

        // Solid frame with the probe back in range.
        probe_x = 11'd5;
        drive_frame(-1, 1'b1, 1'b1, 2, 1'b1);
        drive_frame(-1, 1'b0, 1'b1, 2, 1'b1);

        repeat (8) drive_clk(1'b1, 1'b1, 12'h000);
        check("de_q_drained", de_q.size(), 32'd0);
        check("probe_q_drained", probe_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side counterpart of the VGA timing driver: consumes vga_hs, vga_vs and vga_rgb on the pixel clock and rebuilds pixel coordinates from the sync edges.
- Measures line and frame periods, locks when they match the programmed 640x480@60 timing, counts timing errors, and captures the RGB value at one selectable probe pixel.
- Sits alongside the display path as an on-chip loopback checker; its results are readable by the CPU through MMIO.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_DISP, 640, active pixels per line
- H_TOTAL, 800, pixel clocks per line
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- V_DISP, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, sync active level (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- vga_clk  in  1  pixel clock; all logic runs on this clock
- vga_rst  in  1  synchronous reset, active-high
- vga_hs  in  1  horizontal sync from the driver
- vga_vs  in  1  vertical sync from the driver
- vga_rgb  in  12  pixel data, 4:4:4
- probe_x  in  11  probe column, 0..H_DISP-1
- probe_y  in  11  probe row, 0..V_DISP-1
- pixel_xpos  out  11  reconstructed active column
- pixel_ypos  out  11  reconstructed active row
- pixel_de  out  1  high while (xpos, ypos) is inside the active area
- h_period  out  11  last measured line length in clocks
- v_lines  out  11  last measured frame length in lines
- locked  out  1  timing lock status
- err_cnt  out  16  timing error count, saturating
- probe_rgb  out  12  captured probe pixel
- probe_valid  out  1  one-cycle pulse when probe_rgb updates
- frame_sum  out  16  per-frame checksum (optional feature)

Behaviour:
- Input sampling: hs, vs and rgb are registered once (s_hs, s_vs, s_rgb), and one more delayed copy of hs and vs is kept.
  - hs_start is high when the registered hs goes from inactive to the SYNC_POL level; vs_start is defined the same way.
  - Total latency from an input edge to the counter effect is 2 clocks.
- h_cnt (11 bits):
  - On hs_start: h_period <= h_cnt+1 and h_cnt <= 0.
  - Otherwise h_cnt increments, saturating at 2047.
- v_cnt (11 bits):
  - On vs_start: v_lines <= v_cnt+1 and v_cnt <= 0. vs_start takes priority over an hs_start in the same cycle; v_cnt does not also increment.
  - Otherwise, on hs_start, v_cnt increments, saturating at 2047.
- Active-area decode:
  - pixel_de = (h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP)) AND (v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP)).
  - pixel_xpos = h_cnt-(H_SYNC+H_BACK) and pixel_ypos = v_cnt-(V_SYNC+V_BACK) when pixel_de is high; both are 0 otherwise. All three are registered.
- Lock FSM, states SEARCH, TRACK, LOCKED, evaluated at each vs_start:
  - A frame is good when v_lines_new == V_TOTAL and every h_period latched in that frame == H_TOTAL. A per-frame bad flag is set on any mismatch and cleared at vs_start.
  - SEARCH: the first vs_start goes to TRACK with good_cnt=0. The first frame is never judged.
  - TRACK: a good frame increments good_cnt; reaching LOCK_FRAMES goes to LOCKED. A bad frame clears good_cnt and stays in TRACK.
  - LOCKED: a bad frame goes to TRACK with good_cnt=0 and increments err_cnt.
  - In any state, h_cnt saturating at 2047 with no hs_start goes to SEARCH and increments err_cnt once.
  - locked = (state == LOCKED).
- err_cnt saturates at 16'hFFFF.
- Probe capture:
  - probe_x and probe_y are sampled at vs_start and held for the frame. Out-of-range values never match.
  - When pixel_de is high and xpos/ypos equal the sampled probe, probe_rgb <= s_rgb (aligned) and probe_valid pulses for 1 clock. This happens once per frame.
- Reset values:
  - All counters, h_period, v_lines, xpos, ypos, de, err_cnt, probe_rgb, probe_valid and frame_sum are 0.
  - State is SEARCH and locked is 0.
  - Reset mid-frame discards partial measurements; the next vs_start is treated as the first edge.

Optional Feature:
- VGA_MON_CHECKSUM_EN defined:
  - An accumulator adds {4'b0, s_rgb} modulo 2^16 on every pixel_de cycle.
  - At vs_start, frame_sum <= accumulator and the accumulator clears.
- VGA_MON_CHECKSUM_EN undefined: frame_sum is constant 0 and no accumulator logic exists.

Test Plan:
- Nominal 800x525 timing from the driver with reset released: locked rises at the 3rd vs_start (first frame unjudged plus 2 good frames); h_period=800, v_lines=525, err_cnt=0.
- Active decode: pixel_de first rises 144+2 clocks after hs_start on line 35; xpos=0, ypos=0; at the last active pixel xpos=639, ypos=479.
- Probe (100,50) with a driver colour bar at that pixel of 12'hF00: probe_rgb=12'hF00 and exactly one probe_valid pulse per frame. Probe (700,50) gives no pulse.
- While locked, one line shortened to 799 clocks: locked drops at the next vs_start and err_cnt=1; lock is regained after 2 clean frames.
- hs held inactive for 2100 clocks: state goes to SEARCH, err_cnt increments once, locked=0.
- With VGA_MON_CHECKSUM_EN and a solid 12'h001 frame: frame_sum = 640*480 mod 65536 = 45056 (16'hB000).
